store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 16, word address width shared with DMEM.
REQ-002 Parameter DATA_WIDTH, default 32, data word width.
REQ-003 Parameter DEPTH, default 4, entry count; power of two, minimum 2.
REQ-004 Clk  in  1  clock; all state updates on posedge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 StoreValid  in  1  store request from the pipeline.
REQ-007 StoreAddr  in  ADDRESS_WIDTH  store address.
REQ-008 StoreData  in  DATA_WIDTH  store data.
REQ-009 StoreReady  out  1  buffer can accept a store this cycle.
REQ-010 LoadReq  in  1  load request; owns the DMEM port this cycle.
REQ-011 LoadAddr  in  ADDRESS_WIDTH  load address.
REQ-012 LoadData  out  DATA_WIDTH  load result (forwarded or DMEM).
REQ-013 LoadHit  out  1  LoadData came from a buffered store.
REQ-014 LoadStall  out  1  load cannot complete this cycle; pipeline holds it.
REQ-015 MemData  in  DATA_WIDTH  DMEM combinational read data.
REQ-016 Address  out  ADDRESS_WIDTH  DMEM address.
REQ-017 WriteData  out  DATA_WIDTH  DMEM write data.
REQ-018 MemWrite  out  1  DMEM write strobe, sampled by DMEM on posedge.
REQ-019 Count  out  clog2(DEPTH)+1  occupied entries; Empty  out  1  Count==0.

Function
REQ-020 Circular FIFO of {addr,data}; head/tail pointers wrap modulo DEPTH.
REQ-021 Push: posedge with StoreValid && StoreReady writes entry at tail; StoreReady = (Count < DEPTH), combinational on Count only.
REQ-022 StoreValid while full: request ignored, no state change; requester holds it.
REQ-023 Drain: when !LoadReq && !Empty, Address=head addr, WriteData=head data, MemWrite=1; head pops at the same posedge.
REQ-024 When LoadReq=1: Address=LoadAddr, MemWrite=0, no pop (load has port priority).
REQ-025 When Empty && !LoadReq: MemWrite=0, Address=0, WriteData=0.
REQ-026 Push and pop in one cycle: both pointers advance, Count unchanged; pushes into a full buffer are not accepted even if a pop occurs that cycle.
REQ-027 Minimum store latency: entry pushed at edge N drives MemWrite in cycle N+1 at the earliest.
REQ-028 A store presented in the same cycle as a load is not visible to that load.
REQ-029 Drain order strictly FIFO; duplicate addresses are both written, oldest first.

Reset
REQ-030 Reset=1 at posedge: pointers 0, Count 0, all entries discarded, including any mid-drain.
REQ-031 During/after reset: Empty=1, StoreReady=1, MemWrite=0, LoadHit=0, LoadStall=0; Reset dominates StoreValid.

Configuration
REQ-032 Macro STORE_BUFFER_FWD_EN.
REQ-033 Defined: LoadAddr is compared with all valid entries; on any match, LoadHit=1 and LoadData=data of the youngest matching entry; otherwise LoadData=MemData; LoadStall=0 always.
REQ-034 Undefined: no comparators; LoadHit=0, LoadData=MemData; LoadStall = LoadReq && !Empty, and while LoadStall=1 drain proceeds (REQ-024 waived) until Empty.

Verification
REQ-035 Reset, then push A=0x0010/D=0xDEADBEEF -> next cycle MemWrite=1, Address=0x0010, WriteData=0xDEADBEEF; following cycle Empty=1.
REQ-036 Hold LoadReq=1 and push 4 stores -> Count=4, StoreReady=0; 5th store ignored; release LoadReq -> 4 writes in order, one per cycle.
REQ-037 FWD_EN: push 0x0020/0x11, then 0x0020/0x22 with LoadReq=1, LoadAddr=0x0020 -> LoadHit=1, LoadData=0x22; LoadAddr=0x0030 -> LoadHit=0, LoadData=MemData.
REQ-038 Full buffer, pop and StoreValid same cycle -> Count 4->3, store not taken; retry next cycle accepted, Count=4.
REQ-039 Reset asserted with Count=3 mid-drain -> next cycle Count=0, MemWrite=0, no further DMEM writes.
REQ-040 FWD_EN undefined: Count=2, LoadReq=1 -> LoadStall=1 two cycles while draining, then LoadStall=0, Address=LoadAddr.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of pending {addr,data} stores drained to DMEM whenever loads leave the port idle.
// Macro STORE_BUFFER_FWD_EN: loads forward from the youngest matching entry; undefined, loads stall until the buffer drains.
module store_buffer #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     StoreValid,
  input  logic [ADDRESS_WIDTH-1:0] StoreAddr,
  input  logic [DATA_WIDTH-1:0]    StoreData,
  output logic                     StoreReady,
  input  logic                     LoadReq,
  input  logic [ADDRESS_WIDTH-1:0] LoadAddr,
  output logic [DATA_WIDTH-1:0]    LoadData,
  output logic                     LoadHit,
  output logic                     LoadStall,
  input  logic [DATA_WIDTH-1:0]    MemData,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0]    WriteData,
  output logic                     MemWrite,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem [DEPTH];
  logic [PW-1:0]            head;
  logic [PW-1:0]            tail;
  logic                     push;
  logic                     pop;

  assign Empty      = (Count == '0);
  assign StoreReady = (Count < CW'(DEPTH));
  assign push       = StoreValid && StoreReady && !Reset;

`ifdef STORE_BUFFER_FWD_EN
  assign pop = !Reset && !Empty && !LoadReq;
`else
  // Without forwarding the buffer must empty before a load can safely read DMEM.
  assign pop = !Reset && !Empty;
`endif

  assign MemWrite  = pop;
  assign WriteData = pop ? data_mem[head] : '0;

  always_comb begin
    Address = '0;
    if (pop)
      Address = addr_mem[head];
    else if (LoadReq)
      Address = LoadAddr;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      Count <= '0;
    end else begin
      if (push)
        tail <= tail + PW'(1);
      if (pop)
        head <= head + PW'(1);
      Count <= Count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage needs no reset: occupancy is defined by the pointers and Count.
  always_ff @(posedge Clk) begin
    if (push) begin
      addr_mem[tail] <= StoreAddr;
      data_mem[tail] <= StoreData;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    LoadHit  = 1'b0;
    LoadData = MemData;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (!Reset && (CW'(i) < Count) && (addr_mem[idx] == LoadAddr)) begin
        LoadHit  = 1'b1;
        LoadData = data_mem[idx];
      end
    end
  end

  assign LoadStall = 1'b0;
`else
  assign LoadHit   = 1'b0;
  assign LoadData  = MemData;
  assign LoadStall = LoadReq && !Empty && !Reset;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: DMEM write scoreboard plus per-scenario checks.
module tb_store_buffer;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          store_valid;
  logic [AW-1:0] store_addr;
  logic [DW-1:0] store_data;
  logic          store_ready;
  logic          load_req;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_hit;
  logic          load_stall;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic          mem_write;
  logic [CW-1:0] count;
  logic          empty;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 1'b0;
  bit  m_push, m_pop, m_drain;

  store_buffer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .Clk(clk), .Reset(reset),
    .StoreValid(store_valid), .StoreAddr(store_addr), .StoreData(store_data), .StoreReady(store_ready),
    .LoadReq(load_req), .LoadAddr(load_addr), .LoadData(load_data), .LoadHit(load_hit), .LoadStall(load_stall),
    .MemData(mem_data), .Address(address), .WriteData(write_data), .MemWrite(mem_write),
    .Count(count), .Empty(empty)
  );

  // DMEM read data is a recognisable function of the address it is given.
  assign mem_data = {16'hC0DE, address};

  always #5 clk = ~clk;

  // Reference occupancy: accepted stores are queued, drains pop the oldest.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      m_push = store_valid && (exp_q.size() < DEPTH);
      m_pop  = (exp_q.size() > 0) && (!load_req || !FWD);
      if (m_pop)
        void'(exp_q.pop_front());
      if (m_push)
        exp_q.push_back(wr_t'{a: store_addr, d: store_data});
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      m_drain = !reset && (exp_q.size() > 0) && (!load_req || !FWD);
      tests++;
      if (mem_write !== m_drain) begin
        fails++;
        $display("FAIL mon_memwrite: got %b expected %b at %0t", mem_write, m_drain, $time);
      end
      if (m_drain) begin
        tests++;
        if (address !== exp_q[0].a || write_data !== exp_q[0].d) begin
          fails++;
          $display("FAIL mon_write: got %h/%h expected %h/%h at %0t",
                   address, write_data, exp_q[0].a, exp_q[0].d, $time);
        end
      end
      tests++;
      if (count !== CW'(exp_q.size())) begin
        fails++;
        $display("FAIL mon_count: got %0d expected %0d at %0t", count, exp_q.size(), $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    tests++;
    if (count !== '0 || empty !== 1'b1 || store_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: got count=%0d empty=%b ready=%b expected 0/1/1", count, empty, store_ready);
    end
    tests++;
    if (mem_write !== 1'b0 || load_hit !== 1'b0 || load_stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got mw=%b hit=%b stall=%b expected 0/0/0", mem_write, load_hit, load_stall);
    end
    step();
    reset = 1'b0;
    store_valid = 1'b0;
    mon_en = 1'b1;
    #1;
    tests++;
    if (count !== '0 || address !== '0 || write_data !== '0) begin
      fails++;
      $display("FAIL reset_idle: got count=%0d addr=%h wd=%h expected 0/0/0", count, address, write_data);
    end
  endtask

  task automatic test_single();
    store_valid = 1'b1;
    store_addr  = 16'h0010;
    store_data  = 32'hDEADBEEF;
    step();
    store_valid = 1'b0;
    #1;
    tests++;
    if (mem_write !== 1'b1 || address !== 16'h0010 || write_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL single_write: got mw=%b %h/%h expected 1 0010/deadbeef", mem_write, address, write_data);
    end
    step();
    #1;
    tests++;
    if (empty !== 1'b1 || mem_write !== 1'b0 || address !== '0 || write_data !== '0) begin
      fails++;
      $display("FAIL single_empty: got empty=%b mw=%b %h/%h expected 1 0 0/0", empty, mem_write, address, write_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [6];
    addrs = '{16'h0080, 16'h0084, 16'h0080, 16'h0088, 16'h008C, 16'h0080};
    for (int i = 0; i < 6; i++) begin
      store_valid = 1'b1;
      store_addr  = addrs[i];
      store_data  = $urandom;
      step();
      tests++;
      if (count !== CW'(1)) begin
        fails++;
        $display("FAIL b2b_count: got %0d expected 1 (store %0d)", count, i);
      end
    end
    store_valid = 1'b0;
    step();
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL b2b_empty: got %b expected 1", empty);
    end
  endtask

`ifdef STORE_BUFFER_FWD_EN
  task automatic test_fill();
    load_req  = 1'b1;
    load_addr = 16'h0999;
    for (int i = 0; i < DEPTH; i++) begin
      store_valid = 1'b1;
      store_addr  = 16'h0040 + AW'(i);
      store_data  = $urandom;
      step();
    end
    tests++;
    if (count !== CW'(DEPTH) || store_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_full: got count=%0d ready=%b expected 4/0", count, store_ready);
    end
    store_addr = 16'h0050;
    step();
    tests++;
    if (count !== CW'(DEPTH)) begin
      fails++;
      $display("FAIL fill_ignore: got count=%0d expected 4", count);
    end
    store_valid = 1'b0;
    load_req    = 1'b0;
    #1;
    tests++;
    if (mem_write !== 1'b1 || address !== 16'h0040) begin
      fails++;
      $display("FAIL fill_first: got mw=%b addr=%h expected 1/0040", mem_write, address);
    end
    repeat (DEPTH) step();
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL fill_drained: got empty=%b expected 1", empty);
    end
  endtask

  task automatic test_full_retry();
    load_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      store_valid = 1'b1;
      store_addr  = 16'h0060 + AW'(i);
      store_data  = $urandom;
      step();
    end
    load_req   = 1'b0;
    store_addr = 16'h0070;
    store_data = 32'h7070_7070;
    #1;
    tests++;
    if (store_ready !== 1'b0) begin
      fails++;
      $display("FAIL retry_ready_full: got %b expected 0", store_ready);
    end
    step();
    tests++;
    if (count !== CW'(3) || store_ready !== 1'b1) begin
      fails++;
      $display("FAIL retry_popped: got count=%0d ready=%b expected 3/1", count, store_ready);
    end
    load_req = 1'b1;
    step();
    tests++;
    if (count !== CW'(4)) begin
      fails++;
      $display("FAIL retry_accept: got count=%0d expected 4", count);
    end
    store_valid = 1'b0;
    load_req    = 1'b0;
    repeat (DEPTH) step();
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL retry_drained: got empty=%b expected 1", empty);
    end
  endtask

  task automatic test_forward();
    store_valid = 1'b1;
    store_addr  = 16'h0020;
    store_data  = 32'h11;
    load_req    = 1'b1;
    load_addr   = 16'h0020;
    #1;
    tests++;
    if (load_hit !== 1'b0 || load_data !== 32'hC0DE0020) begin
      fails++;
      $display("FAIL fwd_same_cycle: got hit=%b data=%h expected 0/c0de0020", load_hit, load_data);
    end
    step();
    store_data = 32'h22;
    #1;
    tests++;
    if (load_hit !== 1'b1 || load_data !== 32'h11) begin
      fails++;
      $display("FAIL fwd_first: got hit=%b data=%h expected 1/00000011", load_hit, load_data);
    end
    step();
    store_valid = 1'b0;
    #1;
    tests++;
    if (load_hit !== 1'b1 || load_data !== 32'h22 || load_stall !== 1'b0) begin
      fails++;
      $display("FAIL fwd_youngest: got hit=%b data=%h stall=%b expected 1/00000022/0", load_hit, load_data, load_stall);
    end
    load_addr = 16'h0030;
    #1;
    tests++;
    if (load_hit !== 1'b0 || load_data !== 32'hC0DE0030) begin
      fails++;
      $display("FAIL fwd_miss: got hit=%b data=%h expected 0/c0de0030", load_hit, load_data);
    end
    load_req = 1'b0;
    step();
    step();
    tests++;
    if (empty !== 1'b1) begin
      fails++;
      $display("FAIL fwd_drained: got empty=%b expected 1", empty);
    end
  endtask
`else
  task automatic test_stall();
    store_valid = 1'b1;
    store_addr  = 16'h0200;
    store_data  = 32'hAAAA_0001;
    step();
    load_req   = 1'b1;
    load_addr  = 16'h0300;
    store_addr = 16'h0204;
    store_data = 32'hBBBB_0002;
    #1;
    tests++;
    if (load_stall !== 1'b1 || mem_write !== 1'b1 || address !== 16'h0200) begin
      fails++;
      $display("FAIL stall_first: got stall=%b mw=%b addr=%h expected 1/1/0200", load_stall, mem_write, address);
    end
    step();
    store_valid = 1'b0;
    #1;
    tests++;
    if (load_stall !== 1'b1 || address !== 16'h0204 || count !== CW'(1)) begin
      fails++;
      $display("FAIL stall_second: got stall=%b addr=%h count=%0d expected 1/0204/1", load_stall, address, count);
    end
    step();
    tests++;
    if (load_stall !== 1'b0 || mem_write !== 1'b0 || address !== 16'h0300) begin
      fails++;
      $display("FAIL stall_release: got stall=%b mw=%b addr=%h expected 0/0/0300", load_stall, mem_write, address);
    end
    tests++;
    if (load_hit !== 1'b0 || load_data !== 32'hC0DE0300) begin
      fails++;
      $display("FAIL stall_load: got hit=%b data=%h expected 0/c0de0300", load_hit, load_data);
    end
    load_req = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_drain();
    int exp_mid;
`ifdef STORE_BUFFER_FWD_EN
    load_req = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      store_valid = 1'b1;
      store_addr  = 16'h00A0 + AW'(i);
      store_data  = $urandom;
      step();
    end
    store_valid = 1'b0;
    load_req    = 1'b0;
    step();
    exp_mid = DEPTH - 1;
`else
    store_valid = 1'b1;
    store_addr  = 16'h00A0;
    store_data  = $urandom;
    step();
    store_valid = 1'b0;
    exp_mid = 1;
`endif
    #1;
    tests++;
    if (count !== CW'(exp_mid) || mem_write !== 1'b1) begin
      fails++;
      $display("FAIL mid_drain: got count=%0d mw=%b expected %0d/1", count, mem_write, exp_mid);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (mem_write !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_mw: got %b expected 0", mem_write);
    end
    step();
    reset = 1'b0;
    #1;
    tests++;
    if (count !== '0 || mem_write !== 1'b0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_after: got count=%0d mw=%b empty=%b expected 0/0/1", count, mem_write, empty);
    end
    step();
    step();
    tests++;
    if (mem_write !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_quiet: got mw=%b expected 0", mem_write);
    end
  endtask

  initial begin
    reset       = 1'b1;
    store_valid = 1'b1;
    store_addr  = 16'h0055;
    store_data  = 32'h1234_5678;
    load_req    = 1'b0;
    load_addr   = '0;
    test_reset();
    test_single();
    test_back_to_back();
`ifdef STORE_BUFFER_FWD_EN
    test_fill();
    test_full_retry();
    test_forward();
`else
    test_stall();
`endif
    test_reset_mid_drain();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
